piso_sequencer: RTL and testbench
=================================

# piso_sequencer

Controller that sequences a parameterised parallel-load shift register as a parallel-in/serial-out transmitter. It accepts a WIDTH-bit word over a valid/ready handshake, loads it into the register and shifts it out LSB-first with a programmable bit period. On completion it pulses `done`. It sits between a word producer (CPU/bus side) and any single-wire serial consumer in the datapath.

## Interface
- `WIDTH`, 4: word width in bits; must be ≥2.
- `CLKS_PER_BIT`, 1: clock cycles each bit is held on `ser_out`; must be ≥1.
- `FILL`, 1'b0: value shifted into the MSB on each shift.
- `Clock`  in  1  single clock; all state updates on the rising edge.
- `Resetn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer has a word on `in_data`.
- `in_data`  in  WIDTH  word to transmit.
- `in_ready`  out  1  sequencer can accept a word.
- `abort`  in  1  synchronous cancel of the current transfer.
- `ser_out`  out  1  serial data, which is register bit 0.
- `ser_valid`  out  1  `ser_out` carries a valid bit.
- `busy`  out  1  a transfer is in progress (SHIFT or DONE).
- `done`  out  1  one-cycle pulse after the last bit completes.

## Operation
- **FSM states:** IDLE, SHIFT, DONE.
- **IDLE:**
  - `in_ready`=1.
  - On an edge with `in_valid`=1: the shift register parallel-loads `in_data`, the bit counter is set to 0, the period counter is set to 0, and the FSM goes to SHIFT.
  - `abort` is ignored in IDLE.
- **SHIFT:**
  - `ser_valid`=1 and `ser_out`=Q[0].
  - The period counter increments every cycle.
  - When the period counter reaches CLKS_PER_BIT-1:
    - it wraps to 0;
    - if the bit counter is below WIDTH-1, the register shifts one place toward bit 0 with FILL entering the MSB, and the bit counter increments;
    - if the bit counter equals WIDTH-1, the FSM goes to DONE and no shift occurs.
- **DONE:** `done`=1 for this single cycle, `in_ready`=0, then the FSM goes to IDLE.
- **abort=1 in SHIFT:** the FSM goes to IDLE on the next edge. `done` is not asserted and the register contents are left as-is. `abort` in DONE is ignored.
- **Simultaneous abort and last-bit completion:** abort wins and the FSM goes to IDLE with no `done`.
- **Counter widths:** bit counter is $clog2(WIDTH) bits; period counter is max(1, $clog2(CLKS_PER_BIT)) bits. Neither counter may exceed its terminal value.
- **Input handling:** `in_data` is sampled only on the accept edge, so later changes have no effect. `in_valid` outside IDLE is ignored and not queued.

## Timing
- **Reset values (asynchronous, immediate on `Resetn`=0):** state=IDLE, register=0, counters=0. Outputs: `in_ready`=1, `ser_out`=0, `ser_valid`=0, `busy`=0, `done`=0.
- **Reset mid-transfer:** the transfer is lost with no `done`. Normal operation resumes on the first edge after `Resetn` rises.
- **Transfer sequence:** let the accept be at edge k, with W=WIDTH and C=CLKS_PER_BIT.
  - Bit i (0-based) is on `ser_out` during cycles k+1+i·C through k+(i+1)·C.
  - `ser_valid`=1 for exactly W·C cycles.
  - `done`=1 in cycle k+W·C+1.
  - `in_ready`=1 again from cycle k+W·C+2.
- **Throughput:** one word per W·C+2 cycles.
- **Output decoding:** all outputs are Moore, decoded from state and registers only. `in_ready` has no combinational path from `in_valid`.

## Structure
- **Package `piso_pkg`:** state enum `piso_state_t` {IDLE, SHIFT, DONE} and a function computing counter widths.
- **Sub-module `shiftn`:** WIDTH-bit register with parallel load and shift toward bit 0.
  - Ports: `Clock`, `Resetn`, `R[WIDTH-1:0]`, `L` (load), `E` (shift enable), `w` (MSB fill), `Q`.
  - L has priority over E.
  - When both L and E are 0 the register holds.
- **Top level:** FSM and both counters; it drives `L`/`E` of `shiftn`.

## Test plan
- **Single word, W=4, C=1:** send 4'b1011 at edge 0. `ser_out` is 1,1,0,1 over cycles 1–4, `done` is high in cycle 5, `in_ready` is high in cycle 6.
- **Bit period, W=4, C=3:** send 4'b0110. Each bit is held 3 cycles (0,1,1,0), `ser_valid` is high for exactly 12 cycles, and `done` is high in cycle 13.
- **Back-to-back with in_valid held high:** send 4'hA, then 4'h5. The second accept happens in cycle 6 (C=1), with no overlap and no lost word. A change to `in_data` in cycle 2 has no effect on the bits sent.
- **Abort:** assert `abort` during bit 2 (C=1). The FSM returns to IDLE the next cycle, `done` never asserts, and `in_ready` is 1 one cycle after the abort.
- **Simultaneous abort and last bit:** assert `abort` in the final bit cycle. `done` stays 0 and the FSM is in IDLE next.
- **Reset mid-transfer:** drop `Resetn` during bit 1 between edges. All outputs take reset values immediately. After release, a new word 4'b1000 transmits correctly.

Source files
------------

// File: rtl/piso_pkg.sv
// -----------------------------------------------------------------------------
// piso_pkg
//   Shared types and helpers for the piso_sequencer block.
//   - piso_state_t : sequencer FSM states
//   - cnt_width()  : width of a counter that runs 0 .. n-1 (at least 1 bit)
// -----------------------------------------------------------------------------
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } piso_state_t;

  // A one-state counter still needs one physical bit, so the width never
  // drops below 1 even though $clog2(1) is 0.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_sequencer_shiftn.sv
// -----------------------------------------------------------------------------
// shiftn
//   WIDTH-bit parallel-load shift register, shifting toward bit 0.
//   Ports:
//     Clock  in   rising-edge clock
//     Resetn in   asynchronous active-low reset (clears Q)
//     R      in   parallel load value
//     L      in   load enable (priority over E)
//     E      in   shift enable
//     w      in   value entering the MSB on a shift
//     Q      out  register contents
// -----------------------------------------------------------------------------
module shiftn #(
  parameter int WIDTH = 4
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] R,
  input  logic             L,
  input  logic             E,
  input  logic             w,
  output logic [WIDTH-1:0] Q
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      Q <= '0;
    end else if (L) begin
      Q <= R;
    end else if (E) begin
      Q <= {w, Q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/piso_sequencer.sv
// -----------------------------------------------------------------------------
// piso_sequencer
//   Parallel-in / serial-out transmitter. Accepts a WIDTH-bit word over a
//   valid/ready handshake and sends it LSB-first, each bit held for
//   CLKS_PER_BIT cycles, then pulses done for one cycle.
//   Ports:
//     Clock      in   rising-edge clock
//     Resetn     in   asynchronous active-low reset
//     in_valid   in   producer has a word on in_data
//     in_data    in   word to transmit (sampled only on the accept edge)
//     in_ready   out  sequencer can accept a word (IDLE)
//     abort      in   synchronous cancel of the current transfer (SHIFT only)
//     ser_out    out  serial data (register bit 0)
//     ser_valid  out  ser_out carries a valid bit (SHIFT)
//     busy       out  transfer in progress (SHIFT or DONE)
//     done       out  one-cycle pulse after the last bit
//   All outputs are decoded from registered state only.
// -----------------------------------------------------------------------------
module piso_sequencer
  import piso_pkg::*;
#(
  parameter int   WIDTH        = 4,
  parameter int   CLKS_PER_BIT = 1,
  parameter logic FILL         = 1'b0
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             abort,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = cnt_width(WIDTH);
  localparam int PW = cnt_width(CLKS_PER_BIT);

  localparam logic [BW-1:0] BIT_LAST    = BW'(WIDTH - 1);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(CLKS_PER_BIT - 1);

  piso_state_t     state_q, state_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [PW-1:0]   per_cnt_q, per_cnt_d;
  logic            load, shift_en;
  logic [WIDTH-1:0] q;

  shiftn #(.WIDTH(WIDTH)) u_shiftn (
    .Clock  (Clock),
    .Resetn (Resetn),
    .R      (in_data),
    .L      (load),
    .E      (shift_en),
    .w      (FILL),
    .Q      (q)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      per_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      per_cnt_q <= per_cnt_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    per_cnt_d = per_cnt_q;
    load      = 1'b0;
    shift_en  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          load      = 1'b1;
          bit_cnt_d = '0;
          per_cnt_d = '0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        // Abort takes priority over end-of-bit handling, including the final
        // bit, and freezes the register where it is.
        if (abort) begin
          state_d = IDLE;
        end else if (per_cnt_q == PERIOD_LAST) begin
          per_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            // Last bit leaves the register unshifted; nothing follows it.
            state_d = DONE;
          end else begin
            shift_en  = 1'b1;
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          per_cnt_d = per_cnt_q + PW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign ser_valid = (state_q == SHIFT);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign ser_out   = q[0];

endmodule

// File: tb/tb_piso_sequencer.sv
// -----------------------------------------------------------------------------
// tb_piso_sequencer
//   Two instances: dut_a (WIDTH=4, CLKS_PER_BIT=1) and dut_b (WIDTH=4,
//   CLKS_PER_BIT=3). Inputs change and outputs are sampled on the falling
//   edge; expected serial bits are queued when a word is driven and popped
//   as the DUT shifts them out.
// -----------------------------------------------------------------------------
module tb_piso_sequencer;

  logic       clk;
  logic       rst_n;

  logic       in_valid_a, in_ready_a, abort_a;
  logic [3:0] in_data_a;
  logic       ser_out_a, ser_valid_a, busy_a, done_a;

  logic       in_valid_b, in_ready_b, abort_b;
  logic [3:0] in_data_b;
  logic       ser_out_b, ser_valid_b, busy_b, done_b;

  int checks   = 0;
  int failures = 0;
  logic exp_q[$];

  piso_sequencer #(.WIDTH(4), .CLKS_PER_BIT(1), .FILL(1'b0)) dut_a (
    .Clock     (clk),
    .Resetn    (rst_n),
    .in_valid  (in_valid_a),
    .in_data   (in_data_a),
    .in_ready  (in_ready_a),
    .abort     (abort_a),
    .ser_out   (ser_out_a),
    .ser_valid (ser_valid_a),
    .busy      (busy_a),
    .done      (done_a)
  );

  piso_sequencer #(.WIDTH(4), .CLKS_PER_BIT(3), .FILL(1'b0)) dut_b (
    .Clock     (clk),
    .Resetn    (rst_n),
    .in_valid  (in_valid_b),
    .in_data   (in_data_b),
    .in_ready  (in_ready_b),
    .abort     (abort_b),
    .ser_out   (ser_out_b),
    .ser_valid (ser_valid_b),
    .busy      (busy_b),
    .done      (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {in_ready, ser_out, ser_valid, busy, done}
  task automatic test_reset;
    logic [4:0] obs;
    obs = {in_ready_a, ser_out_a, ser_valid_a, busy_a, done_a};
    checks++;
    if (obs !== 5'b10000) begin
      failures++;
      $display("FAIL reset_outputs_a: got %b expected 10000", obs);
    end
    obs = {in_ready_b, ser_out_b, ser_valid_b, busy_b, done_b};
    checks++;
    if (obs !== 5'b10000) begin
      failures++;
      $display("FAIL reset_outputs_b: got %b expected 10000", obs);
    end
  endtask

  task automatic test_single_word;
    logic [3:0] word;
    logic       b;
    word = 4'b1011;
    @(negedge clk);
    checks++;
    if (in_ready_a !== 1'b1) begin
      failures++;
      $display("FAIL single_idle_ready: got %b expected 1", in_ready_a);
    end
    in_data_a  = word;
    in_valid_a = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(word[i]);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      in_valid_a = 1'b0;
      b = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      checks++;
      if ({ser_valid_a, busy_a, in_ready_a, ser_out_a} !== {3'b110, b}) begin
        failures++;
        $display("FAIL single_bit%0d: got valid/busy/ready/out=%b%b%b%b expected 110%b",
                 cyc - 1, ser_valid_a, busy_a, in_ready_a, ser_out_a, b);
      end
    end
    @(negedge clk);
    checks++;
    if ({done_a, ser_valid_a, in_ready_a, busy_a} !== 4'b1001) begin
      failures++;
      $display("FAIL single_done: got done/valid/ready/busy=%b%b%b%b expected 1001",
               done_a, ser_valid_a, in_ready_a, busy_a);
    end
    @(negedge clk);
    checks++;
    if ({done_a, in_ready_a, busy_a} !== 3'b010) begin
      failures++;
      $display("FAIL single_ready_again: got done/ready/busy=%b%b%b expected 010",
               done_a, in_ready_a, busy_a);
    end
  endtask

  task automatic test_bit_period;
    logic [3:0] word;
    logic       cur;
    int         valid_cycles;
    word = 4'b0110;
    valid_cycles = 0;
    cur = 1'bx;
    @(negedge clk);
    in_data_b  = word;
    in_valid_b = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(word[i]);
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      in_valid_b = 1'b0;
      if (ser_valid_b) valid_cycles++;
      if (cyc <= 12) begin
        if ((cyc - 1) % 3 == 0) cur = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
        checks++;
        if ({ser_valid_b, ser_out_b} !== {1'b1, cur}) begin
          failures++;
          $display("FAIL period_cycle%0d: got valid/out=%b%b expected 1%b",
                   cyc, ser_valid_b, ser_out_b, cur);
        end
      end
      checks++;
      if (done_b !== (cyc == 13)) begin
        failures++;
        $display("FAIL period_done_cycle%0d: got %b expected %b", cyc, done_b, cyc == 13);
      end
    end
    checks++;
    if (valid_cycles != 12) begin
      failures++;
      $display("FAIL period_valid_count: got %0d expected 12", valid_cycles);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] w1, w2;
    logic       b;
    w1 = 4'hA;
    w2 = 4'h5;
    @(negedge clk);
    in_data_a  = w1;
    in_valid_a = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(w1[i]);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if ((cyc >= 1 && cyc <= 4) || (cyc >= 7 && cyc <= 10)) begin
        b = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
        checks++;
        if ({ser_valid_a, ser_out_a} !== {1'b1, b}) begin
          failures++;
          $display("FAIL b2b_cycle%0d: got valid/out=%b%b expected 1%b",
                   cyc, ser_valid_a, ser_out_a, b);
        end
      end else if (cyc == 5 || cyc == 11) begin
        checks++;
        if ({done_a, in_ready_a} !== 2'b10) begin
          failures++;
          $display("FAIL b2b_done_cycle%0d: got done/ready=%b%b expected 10",
                   cyc, done_a, in_ready_a);
        end
      end else begin
        checks++;
        if ({in_ready_a, busy_a, done_a} !== 3'b100) begin
          failures++;
          $display("FAIL b2b_idle_cycle%0d: got ready/busy/done=%b%b%b expected 100",
                   cyc, in_ready_a, busy_a, done_a);
        end
      end
      // Next word presented mid-transfer; must not disturb the first word.
      if (cyc == 2) in_data_a = w2;
      if (cyc == 6) for (int i = 0; i < 4; i++) exp_q.push_back(w2[i]);
      if (cyc == 7) in_valid_a = 1'b0;
    end
  endtask

  task automatic test_abort;
    logic [3:0] word;
    logic       b;
    word = 4'b0101;
    @(negedge clk);
    in_data_a  = word;
    in_valid_a = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(word[i]);
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      in_valid_a = 1'b0;
      b = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      checks++;
      if ({ser_valid_a, ser_out_a} !== {1'b1, b}) begin
        failures++;
        $display("FAIL abort_bit%0d: got valid/out=%b%b expected 1%b",
                 cyc - 1, ser_valid_a, ser_out_a, b);
      end
    end
    abort_a = 1'b1;
    exp_q.delete();
    @(negedge clk);
    abort_a = 1'b0;
    checks++;
    if ({in_ready_a, ser_valid_a, busy_a, done_a} !== 4'b1000) begin
      failures++;
      $display("FAIL abort_idle: got ready/valid/busy/done=%b%b%b%b expected 1000",
               in_ready_a, ser_valid_a, busy_a, done_a);
    end
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      checks++;
      if (done_a !== 1'b0) begin
        failures++;
        $display("FAIL abort_no_done%0d: got %b expected 0", cyc, done_a);
      end
    end
  endtask

  task automatic test_abort_last;
    logic [3:0] word;
    logic       b;
    word = 4'b1001;
    @(negedge clk);
    in_data_a  = word;
    in_valid_a = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(word[i]);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      in_valid_a = 1'b0;
      b = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      checks++;
      if ({ser_valid_a, ser_out_a} !== {1'b1, b}) begin
        failures++;
        $display("FAIL abort_last_bit%0d: got valid/out=%b%b expected 1%b",
                 cyc - 1, ser_valid_a, ser_out_a, b);
      end
    end
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    checks++;
    if ({done_a, in_ready_a, ser_valid_a, busy_a} !== 4'b0100) begin
      failures++;
      $display("FAIL abort_last_idle: got done/ready/valid/busy=%b%b%b%b expected 0100",
               done_a, in_ready_a, ser_valid_a, busy_a);
    end
    @(negedge clk);
    checks++;
    if (done_a !== 1'b0) begin
      failures++;
      $display("FAIL abort_last_no_done: got %b expected 0", done_a);
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0] word;
    logic [4:0] obs;
    logic       b;
    word = 4'b0111;
    @(negedge clk);
    in_data_a  = word;
    in_valid_a = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(word[i]);
    for (int cyc = 1; cyc <= 2; cyc++) begin
      @(negedge clk);
      in_valid_a = 1'b0;
      b = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      checks++;
      if ({ser_valid_a, ser_out_a} !== {1'b1, b}) begin
        failures++;
        $display("FAIL rstmid_bit%0d: got valid/out=%b%b expected 1%b",
                 cyc - 1, ser_valid_a, ser_out_a, b);
      end
    end
    // Reset asserted between clock edges: outputs must respond without a clock.
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    obs = {in_ready_a, ser_out_a, ser_valid_a, busy_a, done_a};
    checks++;
    if (obs !== 5'b10000) begin
      failures++;
      $display("FAIL rstmid_async: got ready/out/valid/busy/done=%b expected 10000", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    word = 4'b1000;
    @(negedge clk);
    in_data_a  = word;
    in_valid_a = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(word[i]);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      in_valid_a = 1'b0;
      b = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      checks++;
      if ({ser_valid_a, ser_out_a} !== {1'b1, b}) begin
        failures++;
        $display("FAIL rstmid_new_bit%0d: got valid/out=%b%b expected 1%b",
                 cyc - 1, ser_valid_a, ser_out_a, b);
      end
    end
    @(negedge clk);
    checks++;
    if (done_a !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_new_done: got %b expected 1", done_a);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid_a = 1'b0;
    in_data_a  = '0;
    abort_a    = 1'b0;
    in_valid_b = 1'b0;
    in_data_b  = '0;
    abort_b    = 1'b0;
    #3;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_single_word();
    test_bit_period();
    test_back_to_back();
    test_abort();
    test_abort_last();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
